boot_loader: RTL
================

Name: boot_loader

Overview:
- Upstream of the single-cycle core: receives a program as a byte stream and writes it word-by-word into instruction memory through a dedicated write port.
- Holds the core in reset until a complete frame has been loaded and its checksum verified.
- Frame format: 1 count byte N, then 4N payload bytes (each instruction little-endian), then 1 checksum byte equal to the XOR of all payload bytes.

Parameters:
- ADDR_W, 64, width of the instruction-memory byte address (matches the core's PC width).
- BASE_ADDR, 64'd0, byte address of the first loaded word.
- MAX_WORDS, 16, largest legal N (1..255).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a byte this cycle.
- restart  input  1  single-cycle pulse; reload request from DONE/ERROR.
- im_we  output  1  instruction-memory write strobe, one-cycle pulse.
- im_addr  output  ADDR_W  byte address of the word being written.
- im_wdata  output  32  instruction word.
- core_hold  output  1  1 = keep the core in reset.
- done  output  1  frame loaded and checksum matched.
- error  output  1  bad count or checksum mismatch.
- words_loaded  output  8  number of words written in the current frame.

Behaviour:
- Byte acceptance: a byte is accepted on the rising edge where in_valid & in_ready.
- Reset (reset=0, asynchronous): state=IDLE, core_hold=1, in_ready=1. im_we, im_addr, im_wdata, done, error, words_loaded, checksum accumulator and byte index are all 0.
- States: IDLE, LOAD, CHECK, DONE, ERROR. in_ready=1 in IDLE, LOAD and CHECK; 0 in DONE and ERROR.
- IDLE:
  - On an accepted byte, latch N.
  - N==0 or N>MAX_WORDS -> ERROR.
  - Otherwise -> LOAD, with byte index=0, words_loaded=0, checksum=0.
- LOAD:
  - Each accepted byte is XORed into the checksum and stored in slot b[byte index].
  - On the 4th byte (index 3): im_wdata={b3,b2,b1,b0}, im_addr=BASE_ADDR+4*words_loaded, and im_we=1 for exactly the next cycle. words_loaded increments in that same cycle; byte index wraps to 0.
  - When the word just written is word N: -> CHECK.
  - Bytes may arrive back-to-back. A new byte accepted during the im_we cycle is legal, and im_addr/im_wdata stay stable while im_we=1.
- CHECK:
  - The next accepted byte is compared to the checksum. This byte is not XORed in.
  - Equal -> DONE. Otherwise -> ERROR.
- DONE: done=1, core_hold=0 in the cycle after the checksum byte is accepted.
- ERROR: error=1, core_hold=1. Words already written are not rolled back.
- restart:
  - In DONE or ERROR, restart=1 -> IDLE next cycle: core_hold=1, done=0, error=0, words_loaded=0.
  - In IDLE, LOAD or CHECK, restart is ignored.
- in_valid while in_ready=0: the byte is not consumed and state is unchanged.
- Addressing: im_addr arithmetic is modulo 2^ADDR_W. The word index is extended to ADDR_W before the multiply by 4.
- Reset asserted mid-frame: immediate return to reset values. Any partial word is discarded (no im_we).
- Output timing: all outputs are registered. There is no combinational path from in_valid to in_ready.
- Latency: im_we is asserted 1 cycle after the 4th byte of a word; done is asserted 1 cycle after the checksum byte.

Decomposition:
- Shared package: state encoding typedef (IDLE/LOAD/CHECK/DONE/ERROR) and the frame-field constant (count byte width 8).
- One sub-module is natural: word_assembler. It holds the byte index, the 4-byte shift register and the checksum XOR, and signals word_valid; the top-level FSM drives the im_* outputs from it.

Test Plan:
- Nominal load:
  - Stimulus: N=2, bytes 13 00 00 00 93 00 10 00, checksum 0x90.
  - Required: im_we pulses twice, first im_addr=0 with im_wdata=32'h00000013, then im_addr=4 with im_wdata=32'h00100093.
  - Then done=1, core_hold=0, words_loaded=2.
- Bad checksum:
  - Stimulus: same frame with checksum 0x91.
  - Required: both writes still occur, error=1, core_hold=1, in_ready=0, done=0.
- Illegal count:
  - Stimulus: N=0, and separately N=MAX_WORDS+1=17.
  - Required: error=1 the cycle after the count byte, no im_we ever.
- Stalled stream:
  - Stimulus: nominal frame with in_valid toggling 1,0,0,1 between bytes.
  - Required: results identical to the nominal load, im_we exactly twice.
- Reset mid-frame:
  - Stimulus: assert reset after 6 payload bytes of an N=2 frame.
  - Required: only one im_we (addr 0), then all outputs return to reset values and core_hold=1.
  - A fresh nominal frame afterwards loads correctly.
- Restart:
  - Stimulus: after DONE, pulse restart, then send N=1, bytes 6F 00 00 00, checksum 0x6F.
  - Required: core_hold=1 the cycle after restart; then im_addr=0, im_wdata=32'h0000006F, done=1.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and frame field widths.
`timescale 1ns/1ps
package boot_loader_pkg;

    // Frame field widths: one count byte, 32-bit little-endian instruction words.
    localparam int COUNT_W        = 8;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input, instruction-memory write port and status bundle of the boot loader.
`timescale 1ns/1ps
interface boot_loader_if #(
    parameter int ADDR_W = 64
);
    import boot_loader_pkg::*;

    logic [BYTE_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               restart;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [WORD_W-1:0]  im_wdata;
    logic               core_hold;
    logic               done;
    logic               error;
    logic [COUNT_W-1:0] words_loaded;

    // Loader side
    modport slave (
        input  in_data, in_valid, restart,
        output in_ready, im_we, im_addr, im_wdata, core_hold, done, error, words_loaded
    );

    // Stream source / system side
    modport master (
        output in_data, in_valid, restart,
        input  in_ready, im_we, im_addr, im_wdata, core_hold, done, error, words_loaded
    );

endinterface

// File: rtl/boot_loader_word_assembler.sv
// Collects payload bytes into little-endian 32-bit words and keeps the running XOR checksum.
`timescale 1ns/1ps
module boot_loader_word_assembler
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] checksum
);

    logic [1:0]        byte_idx;
    logic [BYTE_W-1:0] b0;
    logic [BYTE_W-1:0] b1;
    logic [BYTE_W-1:0] b2;
    logic [BYTE_W-1:0] csum;

    // Store bytes 0..2 of the current word and fold every payload byte into the checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
            b0       <= '0;
            b1       <= '0;
            b2       <= '0;
            csum     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            csum     <= '0;
        end else if (accept) begin
            case (byte_idx)
                2'd0:    b0 <= data;
                2'd1:    b1 <= data;
                2'd2:    b2 <= data;
                default: ;
            endcase
            csum     <= csum ^ data;
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // The fourth byte goes straight into the word; the top registers it into im_wdata.
    assign word_valid = accept && (byte_idx == 2'd3);
    assign word       = {data, b2, b1, b0};
    assign checksum   = csum;

endmodule

// File: rtl/boot_loader.sv
// Frame-driven instruction-memory loader: writes N words and releases the core on a good checksum.
`timescale 1ns/1ps
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int               ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int               MAX_WORDS = 16
) (
    input  logic           clk,
    input  logic           reset,
    boot_loader_if.slave   bus
);

    localparam logic [COUNT_W-1:0] MAX_N = COUNT_W'(MAX_WORDS);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] words_loaded;
    logic               in_ready;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [WORD_W-1:0]  im_wdata;
    logic               core_hold;
    logic               done;
    logic               error;

    logic               accept;
    logic               asm_clear;
    logic               asm_accept;
    logic               word_valid;
    logic [WORD_W-1:0]  word;
    logic [BYTE_W-1:0]  checksum;

    // in_ready is a register, so acceptance never feeds back into in_ready combinationally.
    assign accept     = bus.in_valid && in_ready;
    assign asm_clear  = (state == S_IDLE) && accept;
    assign asm_accept = (state == S_LOAD) && accept;

    boot_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .accept     (asm_accept),
        .data       (bus.in_data),
        .word_valid (word_valid),
        .word       (word),
        .checksum   (checksum)
    );

    // Frame FSM with registered outputs: count check, word writes, checksum verdict, restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            count        <= '0;
            words_loaded <= '0;
            in_ready     <= 1'b1;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count <= bus.in_data;
                        if (bus.in_data == '0 || bus.in_data > MAX_N) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state        <= S_LOAD;
                            words_loaded <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (word_valid) begin
                        im_we        <= 1'b1;
                        im_addr      <= BASE_ADDR + (ADDR_W'(words_loaded) << 2);
                        im_wdata     <= word;
                        words_loaded <= words_loaded + 8'd1;
                        if (words_loaded + 8'd1 == count) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (bus.in_data == checksum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (bus.restart) begin
                        state        <= S_IDLE;
                        in_ready     <= 1'b1;
                        core_hold    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.im_we        = im_we;
    assign bus.im_addr      = im_addr;
    assign bus.im_wdata     = im_wdata;
    assign bus.core_hold    = core_hold;
    assign bus.done         = done;
    assign bus.error        = error;
    assign bus.words_loaded = words_loaded;

endmodule
